// File: rtl/systolic_pipe.sv
// rtl/systolic_pipe.sv - wavefront-pipelined ROW x COLUMN systolic logic grid; optional out_row port under SYSTOLIC_PIPE_ROWOUT_EN
module systolic_pipe #(
  parameter int ROW    = 4,
  parameter int COLUMN = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROW-1:0]    inRow,
  input  logic [COLUMN-1:0] inColumn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out
`ifdef SYSTOLIC_PIPE_ROWOUT_EN
  ,
  output logic [COLUMN-1:0] out_row
`endif
);

  localparam int D = ROW + COLUMN - 1;

  // Row 0 holds the column boundary, column 0 holds the row boundary; [0][0] is unused.
  typedef logic [ROW:0][COLUMN:0] grid_t;

  // Resolve anti-diagonal k from a grid whose diagonals below k are already valid;
  // every other cell is passed through so later stages still see it.
  function automatic grid_t wave(input grid_t p, input int k);
    grid_t n;
    n = p;
    for (int i = 1; i <= ROW; i++) begin
      for (int j = 1; j <= COLUMN; j++) begin
        if (i + j - 1 == k) begin
          if (i == j)
            n[i][j] = p[i][j-1] & p[i-1][j];
          else if (i < j)
            n[i][j] = p[i][j-1] ^ p[i-1][j];
          else
            n[i][j] = p[i][j-1] | p[i-1][j];
        end
      end
    end
    return n;
  endfunction

  grid_t       head;
  grid_t       stage [1:D];
  grid_t       nxt   [1:D];
  logic [D:1]  vld;
  logic        stall;
  logic        unused_bits;

  // Place the incoming boundary bits into an otherwise empty grid.
  always_comb begin
    head = '0;
    for (int r = 1; r <= ROW; r++) head[r][0] = inRow[r-1];
    for (int c = 1; c <= COLUMN; c++) head[0][c] = inColumn[c-1];
  end

  for (genvar k = 1; k <= D; k++) begin : g_wave
    if (k == 1) begin : g_first
      assign nxt[k] = wave(head, 1);
    end else begin : g_next
      assign nxt[k] = wave(stage[k-1], k);
    end
  end

  assign stall    = vld[D] & ~out_ready;
  assign in_ready = ~stall;

  // Advance all wavefront stages together unless the tail result is being held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int k = 1; k <= D; k++) stage[k] <= '0;
    end else if (!stall) begin
      vld[1] <= in_valid;
      for (int k = 2; k <= D; k++) vld[k] <= vld[k-1];
      for (int k = 1; k <= D; k++) stage[k] <= nxt[k];
    end
  end

  assign out_valid = vld[D];
  assign out       = vld[D] & stage[D][ROW][COLUMN];

`ifdef SYSTOLIC_PIPE_ROWOUT_EN
  // The bottom row travels with its transaction through the tail stage.
  assign out_row     = vld[D] ? stage[D][ROW][COLUMN:1] : '0;
`endif

  // Tail-stage cells other than the result bits are intentionally dropped.
  assign unused_bits = ^stage[D];

endmodule
